// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with a built-in one-second prescaler.
// The loaded value counts down once per second; Done pulses for one cycle when 00 is reached.
module bcd_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PW            = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] LoadValue,
  input  logic       Start,
  input  logic       Pause,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       Done
);

  localparam int unsigned   DW        = 4;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   tens_nxt, ones_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic            done_nxt;
  logic            count_zero;
  logic            tick;

  // Out-of-range nibbles saturate to 9 so the display never shows A..F.
  function automatic logic [DW-1:0] clamp_bcd(input logic [DW-1:0] d);
    return (d > DW'(9)) ? DW'(9) : d;
  endfunction

  assign count_zero = (Tens == '0) && (Ones == '0);
  assign tick       = (presc == TICK_LAST);

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      Tens    <= '0;
      Ones    <= '0;
      presc   <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      Tens    <= tens_nxt;
      Ones    <= ones_nxt;
      presc   <= presc_nxt;
      Running <= (state_nxt == RUN);
      Done    <= done_nxt;
    end
  end

  // Next-state logic; Load overrides Start, which overrides Pause.
  always_comb begin
    state_nxt = state;
    tens_nxt  = Tens;
    ones_nxt  = Ones;
    presc_nxt = presc;
    done_nxt  = 1'b0;

    if (Load) begin
      tens_nxt  = clamp_bcd(LoadValue[7:4]);
      ones_nxt  = clamp_bcd(LoadValue[3:0]);
      presc_nxt = '0;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start && !count_zero) begin
            state_nxt = RUN;
            presc_nxt = '0;
          end
        end
        PAUSED: begin
          // Prescaler is left alone so the partial second resumes.
          if (Start) state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            presc_nxt = '0;
            if (Ones != '0) begin
              ones_nxt = Ones - DW'(1);
            end else begin
              ones_nxt = DW'(9);
              tens_nxt = Tens - DW'(1);
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end

          // A terminal decrement ends the run even if Pause arrives on that edge.
          if (tick && (tens_nxt == '0) && (ones_nxt == '0)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (Pause && !Start) begin
            state_nxt = PAUSED;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with a 4-cycle second.
// Table-driven single-cycle vectors plus hand-written multi-cycle sequences.
module tb_bcd_countdown_timer;

  localparam int unsigned TPS = 4;

  logic       Clock;
  logic       Reset;
  logic       Load;
  logic [7:0] LoadValue;
  logic       Start;
  logic       Pause;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       Running;
  logic       Done;

  int tests_run;
  int tests_failed;

  bcd_countdown_timer #(
    .TICKS_PER_SEC(TPS),
    .PW(3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Load(Load),
    .LoadValue(LoadValue),
    .Start(Start),
    .Pause(Pause),
    .Tens(Tens),
    .Ones(Ones),
    .Running(Running),
    .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       load;
    logic [7:0] value;
    logic       start;
    logic       pause;
    logic [7:0] exp_bcd;
    logic       exp_running;
    logic       exp_done;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] v, input logic st, input logic pz);
    Load = ld; LoadValue = v; Start = st; Pause = pz;
    tick();
    Load = 1'b0; Start = 1'b0; Pause = 1'b0;
  endtask

  function automatic int to_bcd(input int n);
    return ((n / 10) << 4) | (n % 10);
  endfunction

  task automatic check_out(input string name, input int bcd, input int run, input int dn);
    check({name, "_digits"}, int'({Tens, Ones}), bcd);
    check({name, "_running"}, int'(Running), run);
    check({name, "_done"}, int'(Done), dn);
  endtask

  // Runs a countdown from n already started; checks every cycle through Done.
  task automatic count_down(input string name, input int n);
    int exp;
    exp = n;
    for (int c = 1; c <= n * TPS; c++) begin
      tick();
      if (c % TPS == 0) exp--;
      check_out(name, to_bcd(exp), (c < n * TPS) ? 1 : 0, (c == n * TPS) ? 1 : 0);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    Reset = 1'b0; Load = 1'b0; LoadValue = 8'h00; Start = 1'b0; Pause = 1'b0;
    #2 Reset = 1'b1;
    #1 check_out("reset_async", 0, 0, 0);
    tick();
    check_out("reset_held", 0, 0, 0);
    Reset = 1'b0;

    //            load  value  start pause  bcd    run   done
    vecs[0]  = '{1'b1, 8'h3F, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h95, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h2B, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h29, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h29, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h28, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].load, vecs[i].value, vecs[i].start, vecs[i].pause);
      check_out($sformatf("vec%0d", i), int'(vecs[i].exp_bcd),
                int'(vecs[i].exp_running), int'(vecs[i].exp_done));
    end

    // Full countdown 12 -> 00, Done on cycle 48.
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_out("t1_start", 'h12, 1, 0);
    count_down("t1", 12);
    tick();
    check_out("t1_after", 0, 0, 0);

    // Pause mid-second, resume the partial second.
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) tick();
    check_out("t2_pre", 'h09, 1, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check_out("t2_paused", 'h09, 0, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_out("t2_hold", 'h09, 0, 0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_out("t2_resume", 'h09, 1, 0);
    tick();
    check_out("t2_r1", 'h09, 1, 0);
    tick();
    check_out("t2_r2", 'h08, 1, 0);

    // Load during RUN aborts without Done, then a fresh countdown.
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) tick();
    check_out("t4_pre", 'h03, 1, 0);
    drive(1'b1, 8'h07, 1'b0, 1'b0);
    check_out("t4_abort", 'h07, 0, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_out("t4_restart", 'h07, 1, 0);
    count_down("t4", 7);

    // Asynchronous reset mid-second; Start afterwards is ignored.
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    #2 Reset = 1'b1;
    #1 check_out("t5_async", 0, 0, 0);
    tick();
    Reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_out("t5_start_ignored", 0, 0, 0);
    for (int c = 0; c < 6; c++) tick();
    check_out("t5_idle", 0, 0, 0);

    // Load on the terminal edge wins over Done.
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) tick();
    check_out("t6_pre", 'h01, 1, 0);
    drive(1'b1, 8'h45, 1'b0, 1'b0);
    check_out("t6_load", 'h45, 0, 0);
    tick();
    check_out("t6_after", 'h45, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
